// File: rtl/mux_rr_n.sv
// mux_rr_n: N-channel valid/ready multiplexer.
// Each input lane has a one-word holding register. One held word per cycle is
// granted into a registered output stage that honours downstream backpressure.
// Arbitration is round-robin (MODE 0) or fixed lowest-index priority (MODE 1).
// Words offered while a lane is not ready are counted in a saturating counter.
module mux_rr_n #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CH_W       = 2,
  parameter int MODE       = 0
) (
  input  logic                         f2,
  input  logic                         reset_L,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
  input  logic [NUM_CH-1:0]            valid_in,
  output logic [NUM_CH-1:0]            ready_in,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         valid_out,
  output logic [CH_W-1:0]              ch_out,
  input  logic                         ready_out,
  output logic [15:0]                  drop_cnt
);

  logic [NUM_CH-1:0]     hold_valid_q, hold_valid_d;
  logic [DATA_WIDTH-1:0] hold_data_q [NUM_CH];
  logic [DATA_WIDTH-1:0] hold_data_d [NUM_CH];
  logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_out_q, valid_out_d;
  logic [CH_W-1:0]       ch_out_q, ch_out_d;
  logic [15:0]           drop_cnt_q, drop_cnt_d;

  logic                  load_s;
  logic                  grant_vld_s;
  logic [CH_W-1:0]       grant_s;
  logic [4:0]            refused_cnt_s;
  logic [16:0]           drop_sum_s;

  // A lane is ready only when its holding register is empty and reset is not asserted.
  assign ready_in = ~hold_valid_q & {NUM_CH{~reset_L}};
  // The output register may take a new word when it is empty or being drained.
  assign load_s   = ~valid_out_q | ready_out;

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign ch_out    = ch_out_q;
  assign drop_cnt  = drop_cnt_q;

  // Arbiter: pick the winning held word (rotating search or lowest index).
  always_comb begin
    int idx;
    idx         = 0;
    grant_vld_s = 1'b0;
    grant_s     = '0;
    if (MODE == 1) begin
      // Scan downward so the lowest set index is the last one written.
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        grant_s     = hold_valid_q[k] ? CH_W'(k) : grant_s;
        grant_vld_s = grant_vld_s | hold_valid_q[k];
      end
    end else begin
      // Search from rr_ptr, wrapping at NUM_CH (not at 2**CH_W).
      for (int k = 0; k < NUM_CH; k++) begin
        idx = int'(rr_ptr_q) + k;
        idx = (idx >= NUM_CH) ? (idx - NUM_CH) : idx;
        grant_s     = (!grant_vld_s && hold_valid_q[idx]) ? CH_W'(idx) : grant_s;
        grant_vld_s = grant_vld_s | hold_valid_q[idx];
      end
    end
  end

  // Count lanes offering a word that is refused this cycle.
  always_comb begin
    refused_cnt_s = 5'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      refused_cnt_s = refused_cnt_s + 5'(valid_in[i] & ~ready_in[i]);
    end
  end

  assign drop_sum_s = {1'b0, drop_cnt_q} + {12'd0, refused_cnt_s};

  // Next-state: hold capture/release, output stage load or stall, pointer and drop count.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    rr_ptr_d     = rr_ptr_q;
    data_out_d   = data_out_q;
    valid_out_d  = valid_out_q;
    ch_out_d     = ch_out_q;
    drop_cnt_d   = drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];

    for (int i = 0; i < NUM_CH; i++) begin
      if (valid_in[i] && ready_in[i]) begin
        hold_valid_d[i] = 1'b1;
        hold_data_d[i]  = data_in[i*DATA_WIDTH +: DATA_WIDTH];
      end else if (load_s && grant_vld_s && (int'(grant_s) == i)) begin
        hold_valid_d[i] = 1'b0;
      end else begin
        hold_valid_d[i] = hold_valid_q[i];
      end
    end

    if (load_s) begin
      if (grant_vld_s) begin
        data_out_d  = hold_data_q[grant_s];
        ch_out_d    = grant_s;
        valid_out_d = 1'b1;
        if (MODE == 1) begin
          rr_ptr_d = '0;
        end else begin
          rr_ptr_d = (int'(grant_s) == NUM_CH - 1) ? '0 : grant_s + CH_W'(1);
        end
      end else begin
        valid_out_d = 1'b0;
      end
    end else begin
      valid_out_d = valid_out_q;
    end
  end

  // State registers with synchronous reset that discards every held and output word.
  always_ff @(posedge f2) begin
    if (reset_L) begin
      hold_valid_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        hold_data_q[i] <= '0;
      end
      rr_ptr_q    <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      ch_out_q    <= '0;
      drop_cnt_q  <= 16'd0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      rr_ptr_q     <= rr_ptr_d;
      data_out_q   <= data_out_d;
      valid_out_q  <= valid_out_d;
      ch_out_q     <= ch_out_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_mux_rr_n.sv
// Directed testbench for mux_rr_n: a 4-lane round-robin instance, a 4-lane
// fixed-priority instance and a 3-lane round-robin instance share clock,
// reset and downstream ready; each has its own lane stimulus.
module tb_mux_rr_n;

  logic        f2;
  logic        reset_L;
  logic        ready_out;

  logic [31:0] data_in_a;
  logic [3:0]  valid_in_a, ready_in_a;
  logic [7:0]  data_out_a;
  logic        valid_out_a;
  logic [1:0]  ch_out_a;
  logic [15:0] drop_cnt_a;

  logic [31:0] data_in_b;
  logic [3:0]  valid_in_b, ready_in_b;
  logic [7:0]  data_out_b;
  logic        valid_out_b;
  logic [1:0]  ch_out_b;
  logic [15:0] drop_cnt_b;

  logic [23:0] data_in_c;
  logic [2:0]  valid_in_c, ready_in_c;
  logic [7:0]  data_out_c;
  logic        valid_out_c;
  logic [1:0]  ch_out_c;
  logic [15:0] drop_cnt_c;

  int checks;
  int failures;

  mux_rr_n #(.NUM_CH(4), .DATA_WIDTH(8), .CH_W(2), .MODE(0)) u_dut (
    .f2(f2), .reset_L(reset_L), .data_in(data_in_a), .valid_in(valid_in_a),
    .ready_in(ready_in_a), .data_out(data_out_a), .valid_out(valid_out_a),
    .ch_out(ch_out_a), .ready_out(ready_out), .drop_cnt(drop_cnt_a)
  );

  mux_rr_n #(.NUM_CH(4), .DATA_WIDTH(8), .CH_W(2), .MODE(1)) u_dut_fp (
    .f2(f2), .reset_L(reset_L), .data_in(data_in_b), .valid_in(valid_in_b),
    .ready_in(ready_in_b), .data_out(data_out_b), .valid_out(valid_out_b),
    .ch_out(ch_out_b), .ready_out(ready_out), .drop_cnt(drop_cnt_b)
  );

  mux_rr_n #(.NUM_CH(3), .DATA_WIDTH(8), .CH_W(2), .MODE(0)) u_dut3 (
    .f2(f2), .reset_L(reset_L), .data_in(data_in_c), .valid_in(valid_in_c),
    .ready_in(ready_in_c), .data_out(data_out_c), .valid_out(valid_out_c),
    .ch_out(ch_out_c), .ready_out(ready_out), .drop_cnt(drop_cnt_c)
  );

  initial f2 = 1'b0;
  always #5 f2 = ~f2;

  // Advance one rising edge and settle; stimulus and sampling happen here.
  task automatic step();
    @(posedge f2);
    #1;
  endtask

  task automatic do_reset();
    valid_in_a = 4'h0;
    valid_in_b = 4'h0;
    valid_in_c = 3'h0;
    reset_L = 1'b1;
    step();
    step();
    reset_L = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    ready_out  = 1'b1;
    data_in_a  = 32'hFFFF_FFFF;
    valid_in_a = 4'hF;
    reset_L    = 1'b1;
    step();
    checks++;
    if (ready_in_a !== 4'h0) begin
      failures++; $display("FAIL reset_ready_during act=%h exp=%h", ready_in_a, 4'h0);
    end
    step();
    checks++;
    if (valid_out_a !== 1'b0) begin
      failures++; $display("FAIL reset_valid_out act=%b exp=%b", valid_out_a, 1'b0);
    end
    checks++;
    if (data_out_a !== 8'h00) begin
      failures++; $display("FAIL reset_data_out act=%h exp=%h", data_out_a, 8'h00);
    end
    checks++;
    if (ch_out_a !== 2'd0) begin
      failures++; $display("FAIL reset_ch_out act=%0d exp=%0d", ch_out_a, 2'd0);
    end
    checks++;
    if (drop_cnt_a !== 16'd0) begin
      failures++; $display("FAIL reset_drop_cnt act=%0d exp=%0d", drop_cnt_a, 16'd0);
    end
    reset_L    = 1'b0;
    valid_in_a = 4'h0;
    #1;
    checks++;
    if (ready_in_a !== 4'hF) begin
      failures++; $display("FAIL reset_ready_after act=%h exp=%h", ready_in_a, 4'hF);
    end
  endtask

  task automatic test_single_word();
    ready_out  = 1'b1;
    data_in_a  = 32'h00A5_0000;
    valid_in_a = 4'b0100;
    step();
    valid_in_a = 4'h0;
    checks++;
    if (valid_out_a !== 1'b0) begin
      failures++; $display("FAIL single_no_bypass act=%b exp=%b", valid_out_a, 1'b0);
    end
    checks++;
    if (ready_in_a !== 4'b1011) begin
      failures++; $display("FAIL single_ready_held act=%h exp=%h", ready_in_a, 4'b1011);
    end
    step();
    checks++;
    if ({valid_out_a, ch_out_a, data_out_a} !== {1'b1, 2'd2, 8'hA5}) begin
      failures++;
      $display("FAIL single_out act=v%b ch%0d d%h exp=v1 ch2 dA5", valid_out_a, ch_out_a, data_out_a);
    end
    checks++;
    if (ready_in_a !== 4'hF) begin
      failures++; $display("FAIL single_ready_free act=%h exp=%h", ready_in_a, 4'hF);
    end
    step();
    checks++;
    if ({valid_out_a, data_out_a} !== {1'b0, 8'hA5}) begin
      failures++; $display("FAIL single_drain act=v%b d%h exp=v0 dA5", valid_out_a, data_out_a);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    ready_out  = 1'b1;
    data_in_a  = 32'h1312_1110;
    valid_in_a = 4'hF;
    step();
    valid_in_a = 4'h0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({valid_out_a, ch_out_a, data_out_a} !== {1'b1, 2'(i), 8'(8'h10 + i)}) begin
        failures++;
        $display("FAIL rr_seq%0d act=v%b ch%0d d%h exp=v1 ch%0d d%h",
                 i, valid_out_a, ch_out_a, data_out_a, i, 8'(8'h10 + i));
      end
    end
    step();
    checks++;
    if (valid_out_a !== 1'b0) begin
      failures++; $display("FAIL rr_idle act=%b exp=%b", valid_out_a, 1'b0);
    end
    // Pointer must be back at 0: ch0 beats ch3 when both arrive together.
    data_in_a  = 32'h1700_0016;
    valid_in_a = 4'b1001;
    step();
    valid_in_a = 4'h0;
    step();
    checks++;
    if ({ch_out_a, data_out_a} !== {2'd0, 8'h16}) begin
      failures++; $display("FAIL rr_ptr_wrap_first act=ch%0d d%h exp=ch0 d16", ch_out_a, data_out_a);
    end
    step();
    checks++;
    if ({ch_out_a, data_out_a} !== {2'd3, 8'h17}) begin
      failures++; $display("FAIL rr_ptr_wrap_second act=ch%0d d%h exp=ch3 d17", ch_out_a, data_out_a);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ready_out  = 1'b0;
    data_in_a  = 32'h0000_2120;
    valid_in_a = 4'b0011;
    step();
    valid_in_a = 4'h0;
    step();
    checks++;
    if ({valid_out_a, ch_out_a, data_out_a} !== {1'b1, 2'd0, 8'h20}) begin
      failures++; $display("FAIL bp_first act=v%b ch%0d d%h exp=v1 ch0 d20", valid_out_a, ch_out_a, data_out_a);
    end
    data_in_a  = 32'h0000_0022;
    valid_in_a = 4'b0001;
    step();
    data_in_a  = 32'h0000_0023;
    checks++;
    if (drop_cnt_a !== 16'd0) begin
      failures++; $display("FAIL bp_no_drop act=%0d exp=%0d", drop_cnt_a, 16'd0);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({valid_out_a, data_out_a, ready_in_a[1:0]} !== {1'b1, 8'h20, 2'b00}) begin
        failures++;
        $display("FAIL bp_frozen%0d act=v%b d%h rdy%b exp=v1 d20 rdy00",
                 i, valid_out_a, data_out_a, ready_in_a[1:0]);
      end
    end
    checks++;
    if (drop_cnt_a !== 16'd5) begin
      failures++; $display("FAIL bp_drop_cnt act=%0d exp=%0d", drop_cnt_a, 16'd5);
    end
    valid_in_a = 4'h0;
    ready_out  = 1'b1;
    step();
    checks++;
    if ({ch_out_a, data_out_a} !== {2'd1, 8'h21}) begin
      failures++; $display("FAIL bp_resume1 act=ch%0d d%h exp=ch1 d21", ch_out_a, data_out_a);
    end
    step();
    checks++;
    if ({valid_out_a, ch_out_a, data_out_a} !== {1'b1, 2'd0, 8'h22}) begin
      failures++; $display("FAIL bp_resume2 act=v%b ch%0d d%h exp=v1 ch0 d22", valid_out_a, ch_out_a, data_out_a);
    end
    step();
    checks++;
    if ({valid_out_a, drop_cnt_a} !== {1'b0, 16'd5}) begin
      failures++; $display("FAIL bp_end act=v%b drop%0d exp=v0 drop5", valid_out_a, drop_cnt_a);
    end
  endtask

  task automatic test_fixed_priority();
    logic [1:0] exp_ch;
    do_reset();
    ready_out  = 1'b1;
    // ch2 first: a rotating pointer would now favour ch3 over ch1.
    data_in_b  = 32'h0022_0000;
    valid_in_b = 4'b0100;
    step();
    valid_in_b = 4'h0;
    step();
    checks++;
    if ({ch_out_b, data_out_b} !== {2'd2, 8'h22}) begin
      failures++; $display("FAIL fp_ch2 act=ch%0d d%h exp=ch2 d22", ch_out_b, data_out_b);
    end
    data_in_b  = 32'h3300_3100;
    valid_in_b = 4'b1010;
    step();
    valid_in_b = 4'h0;
    step();
    checks++;
    if ({ch_out_b, data_out_b} !== {2'd1, 8'h31}) begin
      failures++; $display("FAIL fp_low_wins act=ch%0d d%h exp=ch1 d31", ch_out_b, data_out_b);
    end
    step();
    checks++;
    if ({ch_out_b, data_out_b} !== {2'd3, 8'h33}) begin
      failures++; $display("FAIL fp_then_high act=ch%0d d%h exp=ch3 d33", ch_out_b, data_out_b);
    end
    valid_in_b = 4'b1010;
    step();
    for (int i = 0; i < 6; i++) begin
      step();
      exp_ch = (i % 2 == 0) ? 2'd1 : 2'd3;
      checks++;
      if ({valid_out_b, ch_out_b} !== {1'b1, exp_ch}) begin
        failures++;
        $display("FAIL fp_alt%0d act=v%b ch%0d exp=v1 ch%0d", i, valid_out_b, ch_out_b, exp_ch);
      end
    end
    valid_in_b = 4'h0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    ready_out  = 1'b0;
    data_in_a  = 32'h4342_4140;
    valid_in_a = 4'hF;
    step();
    valid_in_a = 4'h0;
    step();
    checks++;
    if ({valid_out_a, data_out_a, ready_in_a} !== {1'b1, 8'h40, 4'b0001}) begin
      failures++;
      $display("FAIL mid_setup act=v%b d%h rdy%h exp=v1 d40 rdy1", valid_out_a, data_out_a, ready_in_a);
    end
    reset_L = 1'b1;
    step();
    checks++;
    if ({valid_out_a, data_out_a, ready_in_a} !== {1'b0, 8'h00, 4'h0}) begin
      failures++;
      $display("FAIL mid_in_reset act=v%b d%h rdy%h exp=v0 d00 rdy0", valid_out_a, data_out_a, ready_in_a);
    end
    reset_L   = 1'b0;
    ready_out = 1'b1;
    #1;
    checks++;
    if (ready_in_a !== 4'hF) begin
      failures++; $display("FAIL mid_holds_empty act=%h exp=%h", ready_in_a, 4'hF);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (valid_out_a !== 1'b0) begin
        failures++; $display("FAIL mid_no_stale%0d act=v%b d%h exp=v0", i, valid_out_a, data_out_a);
      end
    end
  endtask

  task automatic test_nch3();
    do_reset();
    ready_out  = 1'b1;
    data_in_c  = 24'h52_5150;
    valid_in_c = 3'b111;
    step();
    valid_in_c = 3'b000;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({valid_out_c, ch_out_c, data_out_c} !== {1'b1, 2'(i), 8'(8'h50 + i)}) begin
        failures++;
        $display("FAIL n3_round1_%0d act=v%b ch%0d d%h exp=v1 ch%0d d%h",
                 i, valid_out_c, ch_out_c, data_out_c, i, 8'(8'h50 + i));
      end
    end
    data_in_c  = 24'h56_5554;
    valid_in_c = 3'b111;
    step();
    valid_in_c = 3'b000;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({valid_out_c, ch_out_c, data_out_c} !== {1'b1, 2'(i), 8'(8'h54 + i)}) begin
        failures++;
        $display("FAIL n3_round2_%0d act=v%b ch%0d d%h exp=v1 ch%0d d%h",
                 i, valid_out_c, ch_out_c, data_out_c, i, 8'(8'h54 + i));
      end
    end
  endtask

  task automatic test_drop_saturation();
    int exp_cnt;
    do_reset();
    ready_out  = 1'b0;
    data_in_a  = 32'h6362_6160;
    valid_in_a = 4'hF;
    // Edge 1 fills all holds, edge 2 moves ch0 out (4 refused), edge 3
    // refills ch0 (3 refused), then every stalled edge refuses 4.
    step();
    step();
    step();
    checks++;
    if (drop_cnt_a !== 16'd7) begin
      failures++; $display("FAIL sat_start act=%0d exp=%0d", drop_cnt_a, 7);
    end
    for (int n = 4; n <= 16386; n++) begin
      step();
      if (n == 10 || n >= 16384) begin
        exp_cnt = 7 + 4 * (n - 3);
        if (exp_cnt > 65535) exp_cnt = 65535;
        checks++;
        if (drop_cnt_a !== 16'(exp_cnt)) begin
          failures++; $display("FAIL sat_edge%0d act=%0d exp=%0d", n, drop_cnt_a, exp_cnt);
        end
      end
    end
    valid_in_a = 4'h0;
    ready_out  = 1'b1;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    reset_L    = 1'b1;
    ready_out  = 1'b1;
    data_in_a  = 32'h0;
    data_in_b  = 32'h0;
    data_in_c  = 24'h0;
    valid_in_a = 4'h0;
    valid_in_b = 4'h0;
    valid_in_c = 3'h0;
    test_reset();
    test_single_word();
    test_round_robin();
    test_backpressure();
    test_fixed_priority();
    test_mid_reset();
    test_nch3();
    test_drop_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_rr_n.md
Name: mux_rr_n

Overview:
- Parametrised N-channel successor to the 2:1 valid/data multiplexer.
- Each channel has a 1-entry holding register with a valid/ready input handshake.
- A round-robin (or fixed-priority) arbiter forwards one held word per cycle into a registered output stage with downstream backpressure.
- Sits between N producer lanes and a single serial consumer in the same datapath.

Parameters:
- NUM_CH, 4, number of input channels (2..16).
- DATA_WIDTH, 8, bits per data word.
- CH_W, 2, width of channel-id output; must equal ceil(log2(NUM_CH)), min 1.
- MODE, 0, 0 = round-robin arbitration, 1 = fixed priority (lowest index wins).

Ports:
- f2  in  1  clock, all logic on rising edge.
- reset_L  in  1  synchronous active-high reset; sampled on the rising edge of f2; 1 = reset (name kept per codebase port naming).
- data_in  in  NUM_CH*DATA_WIDTH  flat input data; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- valid_in  in  NUM_CH  per-channel input valid.
- ready_in  out  NUM_CH  per-channel input ready.
- data_out  out  DATA_WIDTH  registered output data.
- valid_out  out  1  registered output valid.
- ch_out  out  CH_W  channel index of the current data_out.
- ready_out  in  1  downstream ready.
- drop_cnt  out  16  saturating count of input words offered while not ready.

Behaviour:
- Reset (reset_L=1 at an edge):
  - All hold_valid cleared; data_out=0, valid_out=0, ch_out=0, drop_cnt=0.
  - Round-robin pointer rr_ptr=0.
  - Reset mid-transfer discards all held and output words; no partial state survives.
- Input handshake, per channel:
  - ready_in[i] = ~hold_valid[i] & ~reset_L (combinational).
  - A word is accepted when valid_in[i] & ready_in[i] at an edge; hold_data[i] captures data_in slice i and hold_valid[i] is set.
  - There is no same-cycle bypass; a channel accepts at most one word per 2 cycles when it is continuously granted.
- Output stage:
  - load = ~valid_out | ready_out.
  - If load and any hold_valid: grant channel g, set data_out=hold_data[g], ch_out=g, valid_out=1, and clear hold_valid[g] at the same edge.
  - If load and no hold_valid: valid_out=0; data_out and ch_out hold their last values.
  - If ~load: output registers and all hold registers unchanged (stall).
- Latency: input accepted at edge k appears on data_out after edge k+1 (2-cycle minimum), given load is true at k+1 and the channel wins arbitration.
- Arbitration:
  - MODE 0: search hold_valid starting at rr_ptr, wrapping modulo NUM_CH; first set bit wins. On grant, rr_ptr = (g+1) mod NUM_CH. rr_ptr is unchanged when there is no grant or on a stall.
  - MODE 1: lowest set index wins; rr_ptr is unused and stays 0.
- Simultaneous events:
  - A channel granted at edge k has ready_in=1 in cycle k+1, never in the same cycle.
  - All channels valid at once are each served exactly once per NUM_CH grants in MODE 0.
- drop_cnt:
  - Increments by the number of channels with valid_in[i] & ~ready_in[i] at each non-reset edge, i.e. popcount of offered-but-refused words.
  - Saturates at 16'hFFFF; never wraps.
- Arithmetic:
  - rr_ptr wraps at NUM_CH, not at 2^CH_W, for non-power-of-2 NUM_CH.
  - ch_out is zero-extended to CH_W.

Test Plan:
- Reset: hold reset_L=1 for 2 edges with all valid_in=1 -> ready_in=0, valid_out=0, data_out=0, drop_cnt=0 during reset. After release, ready_in=4'hF.
- Single word: ch2 sends 8'hA5 once, ready_out=1 -> valid_out=1, data_out=8'hA5, ch_out=2 exactly 2 edges later; valid_out=0 the next cycle.
- Round robin (MODE 0): all 4 channels load 8'h10..8'h13 simultaneously, ready_out=1 -> ch_out sequence 0,1,2,3 with data 10,11,12,13 on consecutive cycles; rr_ptr ends at 0.
- Backpressure: ready_out=0 for 5 cycles with ch0 and ch1 full -> data_out frozen and ready_in[1:0]=0. Ch0 re-offering a word for 5 cycles -> drop_cnt=5. Raising ready_out resumes in order.
- Fixed priority (MODE 1): ch3 and ch1 continuously valid -> ch1 granted every other cycle; ch3 granted only in gaps when ch1's hold is empty.
- Mid-operation reset: reset_L=1 while valid_out=1 and 3 holds full -> next cycle all holds empty, valid_out=0, no stale data emitted after release. NUM_CH=3 sweep confirms rr_ptr wraps 2->0.
